// File: rtl/match_alu_scheduler.sv
// Round-robin scheduler sharing one opcode-matched ALU between N requesters.
// Optional statistics counters are enabled by defining MATCH_ALU_SCHED_STATS_EN.
module match_alu_scheduler #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int MUL_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*8-1:0]       req_op,
  input  logic [N*W-1:0]       req_a,
  input  logic [N*W-1:0]       req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 busy,
  output logic [1:0]           dbg_state
`ifdef MATCH_ALU_SCHED_STATS_EN
  ,
  output logic [15:0]          op_count,
  output logic [15:0]          stall_count
`endif
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are both high;
  // a request holds valid and payload until ready, a response holds id/data until ready.

  localparam int IW = $clog2(N);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  last_grant;
  logic [IW-1:0]  grant_idx;
  logic           grant_found;
  logic [IW-1:0]  id_q;
  logic [7:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   data_q;
  logic [W-1:0]   alu_res;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           exec_done;
  logic           is_mul;
  int unsigned    scan;

  // Search starts just after the previous winner, so a lone last winner wraps to itself.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int i = 1; i <= N; i++) begin
      scan = (int'(last_grant) + i) % N;
      if (!grant_found && req_valid[scan[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IW-1:0];
      end
    end
  end

  assign is_mul = !((op_q == 8'd17) || (op_q == 8'd21) || (op_q == 8'd34));

  always_comb begin
    alu_res = '0;
    case (op_q)
      8'd17:   alu_res = a_q + W'(1);
      8'd21:   alu_res = a_q + b_q;
      8'd34:   alu_res = a_q - b_q;
      default: alu_res = a_q * b_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    exec_done = 1'b0;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          accept               = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nx             = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!is_mul || (cnt == CW'(MUL_CYCLES - 1))) begin
          exec_done = 1'b1;
          state_nx  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operands are captured at accept so later requester changes cannot disturb the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(N - 1);
      id_q       <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      data_q     <= '0;
    end else begin
      if (accept) begin
        op_q       <= req_op[8*int'(grant_idx) +: 8];
        a_q        <= req_a[W*int'(grant_idx) +: W];
        b_q        <= req_b[W*int'(grant_idx) +: W];
        id_q       <= grant_idx;
        last_grant <= grant_idx;
        cnt        <= '0;
      end else if ((state == S_EXEC) && !exec_done) begin
        cnt <= cnt + CW'(1);
      end
      if (exec_done) begin
        data_q <= alu_res;
      end
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

`ifdef MATCH_ALU_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (op_count != 16'hFFFF)) begin
        op_count <= op_count + 16'd1;
      end
      if (rsp_valid && !rsp_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_match_alu_scheduler.sv
// Scoreboard bench for match_alu_scheduler: directed cases plus randomized traffic
// checked against a plain-arithmetic reference of arbitration, ALU and latency.
module tb_match_alu_scheduler;

  localparam int N          = 4;
  localparam int W          = 8;
  localparam int MUL_CYCLES = 2;
  localparam int IW         = $clog2(N);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*8-1:0]    req_op;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic [1:0]        dbg_state;
`ifdef MATCH_ALU_SCHED_STATS_EN
  logic [15:0]       op_count;
  logic [15:0]       stall_count;
`endif

  match_alu_scheduler #(.N(N), .W(W), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef MATCH_ALU_SCHED_STATS_EN
    ,
    .op_count    (op_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- model state ----------------
  int          errors = 0;
  int          checks = 0;
  bit          pend [N];
  logic [7:0]  p_op [N];
  logic [W-1:0] p_a [N];
  logic [W-1:0] p_b [N];
  int          m_last = N - 1;
  bit          in_flight = 1'b0;
  bit          want_rsp_ready = 1'b1;
  int          m_ops = 0;
  int          m_stalls = 0;
  bit          prev_valid = 1'b0;

  logic [W-1:0]  exp_q[$];
  logic [IW-1:0] exp_id_q[$];
  int            exp_acc_q[$];
  int            exp_lat_q[$];
  int            grants[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_is_mul(input logic [7:0] op);
    return !(op == 8'd17 || op == 8'd21 || op == 8'd34);
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [7:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int r;
    case (op)
      8'd17:   r = int'(a) + 1;
      8'd21:   r = int'(a) + int'(b);
      8'd34:   r = int'(a) - int'(b);
      default: r = int'(a) * int'(b);
    endcase
    r = r & ((1 << W) - 1);
    return r[W-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [7:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    pend[i] = 1'b1;
    p_op[i] = op;
    p_a[i]  = a;
    p_b[i]  = b;
  endtask

  task automatic rand_req(input int i);
    logic [7:0] op;
    case ($urandom_range(0, 3))
      0:       op = 8'd17;
      1:       op = 8'd21;
      2:       op = 8'd34;
      default: op = 8'($urandom);
    endcase
    set_req(i, op, W'($urandom), W'($urandom));
  endtask

  // One clock: drive at negedge, compare the grant against the round-robin model.
  task automatic step();
    logic [N-1:0] exp_ready;
    int g;
    int j;
    @(negedge clk);
    rsp_ready = want_rsp_ready;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_op[8*i +: 8]   = p_op[i];
      req_a[W*i +: W]    = p_a[i];
      req_b[W*i +: W]    = p_b[i];
    end
    #1;
    exp_ready = '0;
    g = -1;
    if (!in_flight) begin
      for (int k = 1; k <= N; k++) begin
        j = (m_last + k) % N;
        if (g < 0 && pend[j]) g = j;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(in_flight));
    if (g >= 0) begin
      exp_q.push_back(ref_alu(p_op[g], p_a[g], p_b[g]));
      exp_id_q.push_back(IW'(g));
      exp_acc_q.push_back(cyc + 1);
      exp_lat_q.push_back(ref_is_mul(p_op[g]) ? MUL_CYCLES : 1);
      grants.push_back(g);
      m_last    = g;
      in_flight = 1'b1;
      pend[g]   = 1'b0;
      p_op[g]   = 8'($urandom);
      p_a[g]    = W'($urandom);
      p_b[g]    = W'($urandom);
    end
    #2;
  endtask

  task automatic wait_accept(input int i);
    for (int t = 0; t < 40 && pend[i]; t++) step();
    if (pend[i]) begin
      chk("accept_timeout", 32'd1, 32'd0);
      pend[i] = 1'b0;
    end
  endtask

  task automatic drain();
    bit any;
    for (int t = 0; t < 200; t++) begin
      any = in_flight;
      for (int i = 0; i < N; i++) any |= pend[i];
      if (!any) break;
      step();
    end
    chk("drain_timeout", 32'(in_flight), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          if (!prev_valid) chk("latency", 32'(cyc - exp_acc_q[0]), 32'(exp_lat_q[0]));
          chk("rsp_id", 32'(rsp_id), 32'(exp_id_q[0]));
          chk("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_id_q.pop_front());
            void'(exp_acc_q.pop_front());
            void'(exp_lat_q.pop_front());
            in_flight = 1'b0;
            m_ops++;
          end else begin
            m_stalls++;
          end
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      p_op[i] = '0;
      p_a[i]  = '0;
      p_b[i]  = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_dbg_state", 32'(dbg_state), 32'd0);
`ifdef MATCH_ALU_SCHED_STATS_EN
    chk("reset_op_count", 32'(op_count), 32'd0);
    chk("reset_stall_count", 32'(stall_count), 32'd0);
`endif
    rst = 1'b0;

    // increment wraps 255 -> 0
    set_req(0, 8'd17, 8'hFF, W'($urandom));
    wait_accept(0);
    drain();
    // add wrap, subtract underflow, lone requester re-granted
    set_req(1, 8'd21, 8'd200, 8'd100);
    drain();
    set_req(2, 8'd34, 8'd5, 8'd10);
    drain();
    set_req(2, 8'd17, 8'd255, 8'd0);
    drain();
    chk("regrant_self", 32'(grants[grants.size()-1]), 32'd2);
    // multiply keeps low bits
    set_req(3, 8'd99, 8'd16, 8'd17);
    drain();

    // all requesters valid: strict rotation
    grants.delete();
    for (int i = 0; i < N; i++) rand_req(i);
    for (int t = 0; t < 100 && grants.size() < 8; t++) begin
      step();
      for (int i = 0; i < N; i++) if (!pend[i]) rand_req(i);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();
    chk("rotation_count", 32'(grants.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk("rotation_order", 32'(grants[k]), 32'(k % N));

    // response stall: five cycles with the consumer not ready, others waiting
    want_rsp_ready = 1'b0;
    begin
      int s0;
      s0 = m_stalls;
      set_req(1, 8'd21, 8'd7, 8'd9);
      wait_accept(1);
      set_req(0, 8'd34, 8'd1, 8'd2);
      set_req(3, 8'd17, 8'd3, 8'd0);
      for (int t = 0; t < 30 && (m_stalls - s0) < 5; t++) step();
    end
    want_rsp_ready = 1'b1;
    drain();
`ifdef MATCH_ALU_SCHED_STATS_EN
    step();
    chk("stall_count", 32'(stall_count), 32'(m_stalls));
`endif

    // reset during a multiply discards it and restores requester 0 priority
    set_req(3, 8'd200, 8'd9, 8'd11);
    wait_accept(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete();
    exp_id_q.delete();
    exp_acc_q.delete();
    exp_lat_q.delete();
    in_flight = 1'b0;
    m_last    = N - 1;
    req_valid = '0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
`ifdef MATCH_ALU_SCHED_STATS_EN
    m_ops    = 0;
    m_stalls = 0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_req(0, 8'd21, 8'd1, 8'd1);
    set_req(2, 8'd34, 8'd0, 8'd1);
    step();
    chk("post_reset_winner", 32'(grants[grants.size()-1]), 32'd0);
    drain();

    // randomized traffic with random drops and response back-pressure
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) rand_req(i);
      end
      want_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    want_rsp_ready = 1'b1;
    drain();
    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MATCH_ALU_SCHED_STATS_EN
    chk("op_count", 32'(op_count), 32'(m_ops));
    chk("stall_count_final", 32'(stall_count), 32'(m_stalls));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
